// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable, sync polarity control,
// registered blanking/display-enable, line/frame strobes, frame counter and synchronous resync.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CW        = 10,
    parameter int FCW       = 8
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    input  logic           clk_en,
    input  logic           resync,
    output logic [CW-1:0]  x_count,
    output logic [CW-1:0]  y_count,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           hblank,
    output logic           vblank,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SSTART = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SSTOP  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SSTART = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SSTOP  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ON     = 1'(HSYNC_POL);
    localparam logic          V_ON     = 1'(VSYNC_POL);

    function automatic logic sync_level(input logic [CW-1:0] pos,
                                        input logic [CW-1:0] start,
                                        input logic [CW-1:0] stop,
                                        input logic          on);
        return (pos >= start && pos < stop) ? on : ~on;
    endfunction

    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          line_wrap;
    logic          frame_wrap;
    logic          first_frame;

    always_comb begin
        line_wrap  = (x_count == H_LAST);
        frame_wrap = line_wrap && (y_count == V_LAST);
        x_nxt      = line_wrap ? '0 : x_count + CW'(1);
        y_nxt      = y_count;
        if (line_wrap) begin
            y_nxt = (y_count == V_LAST) ? '0 : y_count + CW'(1);
        end
    end

    // Levels are derived from the next-state counts so they land in the same register stage
    // as the counters; the reset levels equal those of the last back-porch pixel (H_BP, V_BP >= 1).
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_count     <= H_LAST;
            y_count     <= V_LAST;
            hsync       <= ~H_ON;
            vsync       <= ~V_ON;
            de          <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            first_frame <= 1'b1;
        end else if (resync) begin
            x_count     <= H_LAST;
            y_count     <= V_LAST;
            hsync       <= ~H_ON;
            vsync       <= ~V_ON;
            de          <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            first_frame <= 1'b1;
        end else if (clk_en) begin
            x_count     <= x_nxt;
            y_count     <= y_nxt;
            hsync       <= sync_level(x_nxt, H_SSTART, H_SSTOP, H_ON);
            vsync       <= sync_level(y_nxt, V_SSTART, V_SSTOP, V_ON);
            de          <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
            hblank      <= (x_nxt >= H_ACT);
            vblank      <= (y_nxt >= V_ACT);
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
            // The first frame after reset/resync is a start, not a completion.
            if (frame_wrap) begin
                if (first_frame) begin
                    first_frame <= 1'b0;
                end else begin
                    frame_count <= frame_count + FCW'(1);
                end
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance and one small, inverted-polarity
// instance, both compared every cycle against a position-from-tick-count reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Default-timing instance
    logic       rst_n_a, en_a, rs_a;
    logic [9:0] x_a, y_a;
    logic       hs_a, vs_a, de_a, hb_a, vb_a, ls_a, fs_a;
    logic [7:0] fc_a;

    vga_timing_gen dut_a (
        .pixel_clk(clk), .rst_n(rst_n_a), .clk_en(en_a), .resync(rs_a),
        .x_count(x_a), .y_count(y_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .hblank(hb_a), .vblank(vb_a), .line_start(ls_a), .frame_start(fs_a),
        .frame_count(fc_a)
    );

    // Small-timing, active-low sync instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
    logic       rst_n_b, en_b, rs_b;
    logic [3:0] x_b, y_b;
    logic       hs_b, vs_b, de_b, hb_b, vb_b, ls_b, fs_b;
    logic [7:0] fc_b;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .CW(4), .FCW(8)
    ) dut_b (
        .pixel_clk(clk), .rst_n(rst_n_b), .clk_en(en_b), .resync(rs_b),
        .x_count(x_b), .y_count(y_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .hblank(hb_b), .vblank(vb_b), .line_start(ls_b), .frame_start(fs_b),
        .frame_count(fc_b)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        hs, vs, de, hb, vb, ls, fs;
        logic [7:0]  fc;
    } obs_t;

    // Model state: advances since last reset/resync, frame count carried over a resync,
    // and whether the most recent clock edge advanced the raster.
    int ticks_a = 0, fcb_a = 0;
    bit adv_a = 1'b0;
    int ticks_b = 0, fcb_b = 0;
    bit adv_b = 1'b0;

    function automatic obs_t ref_obs(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                     input bit hpol, vpol,
                                     input int ticks, fc_base, input bit adv);
        obs_t o;
        int ht, vt, ft, p, x, y, frames;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        ft = ht * vt;
        if (ticks == 0) begin
            x = ht - 1; y = vt - 1; frames = 0;
        end else begin
            p = (ticks - 1) % ft;
            x = p % ht; y = p / ht;
            frames = (ticks - 1) / ft + 1;
        end
        o.x  = 16'(x);
        o.y  = 16'(y);
        o.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : !hpol;
        o.vs = (y >= va + vfp && y < va + vfp + vsw) ? vpol : !vpol;
        o.de = (x < ha) && (y < va);
        o.hb = (x >= ha);
        o.vb = (y >= va);
        o.ls = adv && (x == 0);
        o.fs = adv && (x == 0) && (y == 0);
        o.fc = 8'((fc_base + ((frames > 0) ? frames - 1 : 0)) % 256);
        return o;
    endfunction

    function automatic obs_t ref_a();
        return ref_obs(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, ticks_a, fcb_a, adv_a);
    endfunction

    function automatic obs_t ref_b();
        return ref_obs(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, ticks_b, fcb_b, adv_b);
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '{x: 16'(x_a), y: 16'(y_a), hs: hs_a, vs: vs_a, de: de_a, hb: hb_a,
              vb: vb_a, ls: ls_a, fs: fs_a, fc: fc_a};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{x: 16'(x_b), y: 16'(y_b), hs: hs_b, vs: vs_b, de: de_b, hb: hb_b,
              vb: vb_b, ls: ls_b, fs: fs_b, fc: fc_b};
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle_a(input bit en);
        en_a = en;
        @(posedge clk);
        if (en) begin ticks_a++; adv_a = 1'b1; end
        else adv_a = 1'b0;
        #1;
        check("a_model", {17'd0, obs_a()}, {17'd0, ref_a()});
    endtask

    task automatic cycle_b(input bit en, input bit rs);
        en_b = en;
        rs_b = rs;
        @(posedge clk);
        if (rs) begin
            fcb_b   = int'(ref_b().fc);
            ticks_b = 0;
            adv_b   = 1'b0;
        end else if (en) begin
            ticks_b++; adv_b = 1'b1;
        end else begin
            adv_b = 1'b0;
        end
        #1;
        check("b_model", {17'd0, obs_b()}, {17'd0, ref_b()});
    endtask

    typedef struct packed {
        logic       en, rs;
        logic [7:0] pre;
        logic [3:0] x, y;
        logic       de, ls, fs;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int len, hmin, hmax, hlmin, hlmax, vlmin, vlmax, nfs;
        bit got;

        // {en, rs, pre-ticks, x, y, de, line_start, frame_start}, starting from (6,0)
        tbl[0] = {1'b1, 1'b0, 8'd0,  4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = {1'b0, 1'b0, 8'd0,  4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = {1'b0, 1'b0, 8'd0,  4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[3] = {1'b1, 1'b0, 8'd0,  4'd0, 4'd1, 1'b1, 1'b1, 1'b0};
        tbl[4] = {1'b0, 1'b0, 8'd0,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[5] = {1'b1, 1'b0, 8'd0,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[6] = {1'b1, 1'b1, 8'd10, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0};
        tbl[7] = {1'b1, 1'b0, 8'd0,  4'd0, 4'd0, 1'b1, 1'b1, 1'b1};

        rst_n_a = 1'b0; en_a = 1'b0; rs_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0; rs_b = 1'b0;
        #12;
        check("a_reset", 64'({x_a, y_a, hs_a, vs_a, de_a, hb_a, vb_a, ls_a, fs_a, fc_a}),
              64'({10'd799, 10'd524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
        check("b_reset", 64'({x_b, y_b, hs_b, vs_b, de_b, hb_b, vb_b, ls_b, fs_b, fc_b}),
              64'({4'd7, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Default timing: first tick, then one full line
        cycle_a(1'b1);
        check("a_first", 64'({x_a, y_a, de_a, ls_a, fs_a, fc_a}),
              64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0}));
        len = 0; hmin = 99999; hmax = -1; got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            cycle_a(1'b1);
            len++;
            if (hs_a) begin
                if (int'(x_a) < hmin) hmin = int'(x_a);
                if (int'(x_a) > hmax) hmax = int'(x_a);
            end
            if (ls_a) got = 1'b1;
        end
        check("a_line_len", 64'(len), 64'(800));
        check("a_hsync_start", 64'(hmin), 64'(656));
        check("a_hsync_end", 64'(hmax), 64'(751));
        for (int i = 0; i < 200; i++) cycle_a($urandom_range(3) != 0);
        en_a = 1'b0;

        // Small timing: clk_en toggling across the line end, then resync at (3,2)
        repeat (7) cycle_b(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (int'(tbl[i].pre)) cycle_b(1'b1, 1'b0);
            cycle_b(tbl[i].en, tbl[i].rs);
            check($sformatf("tbl%0d", i), 64'({x_b, y_b, de_b, ls_b, fs_b}),
                  64'({tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].ls, tbl[i].fs}));
        end

        // 257 frames after a fresh reset: frame counter wrap and sync pulse positions
        rst_n_b = 1'b0;
        ticks_b = 0; fcb_b = 0; adv_b = 1'b0;
        #3;
        rst_n_b = 1'b1;
        nfs = 0; hlmin = 99; hlmax = -1; vlmin = 99; vlmax = -1;
        for (int i = 0; i < 257 * 48 + 20 && nfs < 257; i++) begin
            cycle_b(1'b1, 1'b0);
            if (!hs_b) begin
                if (int'(x_b) < hlmin) hlmin = int'(x_b);
                if (int'(x_b) > hlmax) hlmax = int'(x_b);
            end
            if (!vs_b) begin
                if (int'(y_b) < vlmin) vlmin = int'(y_b);
                if (int'(y_b) > vlmax) vlmax = int'(y_b);
            end
            if (fs_b) begin
                nfs++;
                if (nfs == 1)   check("b_fc_first", 64'(fc_b), 64'(0));
                if (nfs == 256) check("b_fc_255", 64'(fc_b), 64'(255));
                if (nfs == 257) check("b_fc_wrap", 64'(fc_b), 64'(0));
            end
        end
        check("b_frames_seen", 64'(nfs), 64'(257));
        check("b_hsync_lo_start", 64'(hlmin), 64'(5));
        check("b_hsync_lo_end", 64'(hlmax), 64'(6));
        check("b_vsync_lo_start", 64'(vlmin), 64'(4));
        check("b_vsync_lo_end", 64'(vlmax), 64'(4));

        // Random stall/resync traffic
        for (int i = 0; i < 3000; i++) begin
            cycle_b($urandom_range(3) != 0, $urandom_range(63) == 0);
        end

        // Asynchronous reset mid-line
        repeat (3) cycle_b(1'b1, 1'b0);
        #3;
        rst_n_b = 1'b0;
        ticks_b = 0; fcb_b = 0; adv_b = 1'b0;
        #1;
        check("b_async_reset", 64'({x_b, y_b, hs_b, vs_b, de_b, hb_b, vb_b, ls_b, fs_b, fc_b}),
              64'({4'd7, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
        en_b = 1'b1;
        @(posedge clk);
        #1;
        check("b_reset_held", {17'd0, obs_b()}, {17'd0, ref_b()});
        #3;
        rst_n_b = 1'b1;
        cycle_b(1'b1, 1'b0);
        check("b_after_reset", 64'({x_b, y_b, de_b, ls_b, fs_b}),
              64'({4'd0, 4'd0, 1'b1, 1'b1, 1'b1}));
        cycle_b(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync generator.
- Adds configurable timings and sync polarity, a pixel clock-enable, registered display-enable and blanking, line/frame start strobes, a frame counter and a synchronous resync.
- Sits between the pixel clock domain and the pixel renderer. All outputs are registered and mutually consistent in every cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels, must be >=1)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines, must be >=1)
- HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FCW, 8, frame counter width

Ports:
- pixel_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  advance raster by one pixel this cycle
- resync  in  1  synchronous restart; next enabled tick begins a new frame
- x_count  out  CW  current column
- y_count  out  CW  current line
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  display enable: x<H_ACTIVE and y<V_ACTIVE
- hblank  out  1  x>=H_ACTIVE
- vblank  out  1  y>=V_ACTIVE
- line_start  out  1  one-cycle strobe on the cycle x_count becomes 0
- frame_start  out  1  one-cycle strobe on the cycle (x,y) becomes (0,0)
- frame_count  out  FCW  completed-frame counter, wraps modulo 2^FCW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Invariant: hsync, vsync, de, hblank and vblank are always the registered function of the current x_count/y_count. They are computed from next-state counts, so there is zero skew.
- hsync asserted (=HSYNC_POL) iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; else deasserted (=~HSYNC_POL). vsync follows the same rule using the V parameters and VSYNC_POL.
- Reset (async, rst_n=0):
  - x_count=H_TOTAL-1, y_count=V_TOTAL-1 (last back-porch pixel)
  - de=0, hblank=1, vblank=1
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - line_start=0, frame_start=0, frame_count=0
- Advance (clk_en=1, resync=0):
  - If x==H_TOTAL-1: x<=0. Then y<=0 if y==V_TOTAL-1, else y<=y+1.
  - Otherwise x<=x+1.
- The first enabled tick after reset therefore lands on (0,0) with de=1, line_start=1, frame_start=1.
- Hold (clk_en=0): counters and levels hold; line_start and frame_start forced 0 (strobes never repeat while stalled).
- line_start=1 exactly on cycles where an advance produced x=0. frame_start=1 exactly when an advance produced (0,0).
- frame_count increments on each advance into (0,0), except the first after reset or resync. It wraps from 2^FCW-1 to 0.
- resync=1 (priority over clk_en):
  - Counters load (H_TOTAL-1, V_TOTAL-1); outputs take their reset levels; strobes are 0; frame_count holds.
  - The next enabled tick yields frame_start.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No arithmetic overflow when CW is sized per the rule above.

Test Plan:
- Reset, then clk_en=1 continuous, default parameters:
  - First cycle gives x=0, y=0, de=1, frame_start=1, line_start=1, frame_count=0.
  - hsync high for x=656..751 only.
  - Line length is 800 cycles; frame length is 420000 cycles.
  - vsync high for y=490..491 only.
- HSYNC_POL=0, VSYNC_POL=0, small timings (4/1/2/1, 3/1/1/1):
  - Syncs idle high and pulse low at x=5..6 and y=4.
  - Reset values are hsync=1, vsync=1.
- clk_en toggling 1,0,0,1 across x=7 to x=0:
  - Counters hold during the low cycles.
  - line_start is high for exactly one cycle, on the cycle x becomes 0.
  - de tracks the counters.
- Run 257 frames with FCW=8 and small timings:
  - frame_count reaches 255, then wraps to 0 at the 257th frame_start.
- resync asserted mid-frame at (3,2) with clk_en=1:
  - Next cycle is (H_TOTAL-1, V_TOTAL-1), de=0, no strobe.
  - The following cycle is (0,0) with frame_start=1, and frame_count is unchanged by the resync.
- rst_n asserted asynchronously mid-line:
  - Outputs go to reset values immediately without waiting for a clock edge.
  - After release, the first enabled tick gives (0,0) and frame_start=1.
